// File: rtl/psum_pkg.sv
// Shared types and default widths for the partial-sum accumulator slice.
package psum_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam int PSUM_IN_W  = 23;
  localparam int PSUM_ACC_W = 32;
  localparam int PSUM_CNT_W = 8;

  // Value held by a saturating accumulator of the default width once it clips.
  localparam logic [PSUM_ACC_W-1:0] PSUM_SAT_VAL = {PSUM_ACC_W{1'b1}};

endpackage

// File: rtl/psum_out_reg.sv
// Single-entry valid/ready output register. A load may land in the same
// cycle the held entry drains, so a full register sustains one entry per cycle.
module psum_out_reg #(
  parameter int DATA_W = 41
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic              ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_r;
  logic [DATA_W-1:0] data_r;
  logic              out_fire_s;

  assign out_fire_s = valid_r & out_ready;
  assign ready      = ~valid_r | out_ready;
  assign out_valid  = valid_r;
  assign out_data   = data_r;

  // Load takes priority over drain so a same-cycle replace keeps valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
    end else if (out_fire_s) begin
      valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates adder-tree results over a K-tile group and hands each group sum
// to the drain logic. Define PSUM_ACC_SAT_EN for saturating instead of wrapping.
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int IN_W  = PSUM_IN_W,
  parameter int ACC_W = PSUM_ACC_W,
  parameter int CNT_W = PSUM_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             busy
);

  localparam int PAY_W = ACC_W + CNT_W + 1;

  state_t           state_r, state_nxt_s;
  logic [ACC_W-1:0] acc_r, acc_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             ovf_r, ovf_nxt_s;

  logic [ACC_W:0]   sum_s;
  logic             carry_s;
  logic [ACC_W-1:0] store_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             ovf_grp_s;
  logic             acc_fire_s;
  logic             load_s;
  logic             ready_s;
  logic [PAY_W-1:0] pay_in_s;
  logic [PAY_W-1:0] pay_out_s;

  assign acc_fire_s = in_valid & ready_s;
  assign in_ready   = ready_s;
  assign busy       = (state_r == ACCUM);

  assign sum_s     = {1'b0, acc_r} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
  assign carry_s   = sum_s[ACC_W];
  assign cnt_inc_s = cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
  assign ovf_grp_s = ovf_r | carry_s;

`ifdef PSUM_ACC_SAT_EN
  // Clip to all-ones; a clipped acc carries again on any nonzero beat.
  assign store_s = carry_s ? {ACC_W{1'b1}} : sum_s[ACC_W-1:0];
`else
  assign store_s = sum_s[ACC_W-1:0];
`endif

  assign pay_in_s = {ovf_grp_s, cnt_inc_s, store_s};

  // Group state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      acc_r   <= {ACC_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  // Next-state: IDLE relies on acc/cnt/ovf being zero so the same sum path serves both states.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    cnt_nxt_s   = cnt_r;
    ovf_nxt_s   = ovf_r;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (acc_fire_s) begin
          if (in_last) begin
            load_s = 1'b1;
          end else begin
            state_nxt_s = ACCUM;
            acc_nxt_s   = store_s;
            cnt_nxt_s   = cnt_inc_s;
            ovf_nxt_s   = ovf_grp_s;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCUM: begin
        if (acc_fire_s) begin
          if (in_last) begin
            load_s      = 1'b1;
            state_nxt_s = IDLE;
            acc_nxt_s   = {ACC_W{1'b0}};
            cnt_nxt_s   = {CNT_W{1'b0}};
            ovf_nxt_s   = 1'b0;
          end else begin
            acc_nxt_s = store_s;
            cnt_nxt_s = cnt_inc_s;
            ovf_nxt_s = ovf_grp_s;
          end
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        acc_nxt_s   = {ACC_W{1'b0}};
        cnt_nxt_s   = {CNT_W{1'b0}};
        ovf_nxt_s   = 1'b0;
      end
    endcase
  end

  psum_out_reg #(
    .DATA_W (PAY_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_data (pay_in_s),
    .ready     (ready_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_out_s)
  );

  assign out_data  = pay_out_s[ACC_W-1:0];
  assign out_count = pay_out_s[ACC_W+CNT_W-1:ACC_W];
  assign out_ovf   = pay_out_s[PAY_W-1];

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed self-checking bench for psum_accumulator (default and 24-bit instances).
module tb_psum_accumulator;

  logic        clk;
  logic        rst;
  logic        iv, ordy, il;
  logic [22:0] id;
  logic        irdy, ov, ovf, bsy;
  logic [31:0] od;
  logic [7:0]  oc;

  logic        iv24, ordy24, il24;
  logic [22:0] id24;
  logic        irdy24, ov24, ovf24, bsy24;
  logic [23:0] od24;
  logic [7:0]  oc24;

  int checks;
  int errors;

  psum_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(irdy), .in_data(id), .in_last(il),
    .out_valid(ov), .out_ready(ordy), .out_data(od), .out_count(oc), .out_ovf(ovf), .busy(bsy)
  );

  psum_accumulator #(.IN_W(23), .ACC_W(24), .CNT_W(8)) dut24 (
    .clk(clk), .rst(rst), .in_valid(iv24), .in_ready(irdy24), .in_data(id24), .in_last(il24),
    .out_valid(ov24), .out_ready(ordy24), .out_data(od24), .out_count(oc24), .out_ovf(ovf24),
    .busy(bsy24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [22:0] d, input logic last);
    iv = 1'b1;
    id = d;
    il = last;
    tick();
    iv = 1'b0;
  endtask

  initial begin
    logic [23:0] exp24;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    iv = 1'b0; il = 1'b0; id = 23'd0; ordy = 1'b1;
    iv24 = 1'b0; il24 = 1'b0; id24 = 23'd0; ordy24 = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", {63'd0, ov}, 64'd0);
    chk("rst_out_data", {32'd0, od}, 64'd0);
    chk("rst_out_count", {56'd0, oc}, 64'd0);
    chk("rst_out_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_busy", {63'd0, bsy}, 64'd0);
    chk("rst_in_ready", {63'd0, irdy}, 64'd1);
    rst = 1'b0;
    tick();

    // Three-beat group 100+200+300
    beat(23'd100, 1'b0);
    chk("g3_busy1", {63'd0, bsy}, 64'd1);
    chk("g3_novalid1", {63'd0, ov}, 64'd0);
    beat(23'd200, 1'b0);
    chk("g3_busy2", {63'd0, bsy}, 64'd1);
    beat(23'd300, 1'b1);
    chk("g3_valid", {63'd0, ov}, 64'd1);
    chk("g3_data", {32'd0, od}, 64'd600);
    chk("g3_count", {56'd0, oc}, 64'd3);
    chk("g3_ovf", {63'd0, ovf}, 64'd0);
    chk("g3_idle", {63'd0, bsy}, 64'd0);
    tick();
    chk("g3_drained", {63'd0, ov}, 64'd0);

    // Single-beat group at the tree maximum
    beat(23'h7FFFFF, 1'b1);
    chk("s1_valid", {63'd0, ov}, 64'd1);
    chk("s1_data", {32'd0, od}, 64'h7FFFFF);
    chk("s1_count", {56'd0, oc}, 64'd1);
    chk("s1_idle", {63'd0, bsy}, 64'd0);
    tick();

    // Stall: result held with out_ready low, next beat refused
    ordy = 1'b0;
    beat(23'd1, 1'b1);
    chk("st_valid", {63'd0, ov}, 64'd1);
    chk("st_data", {32'd0, od}, 64'd1);
    iv = 1'b1; id = 23'd50; il = 1'b0;
    #1;
    chk("st_in_ready_low", {63'd0, irdy}, 64'd0);
    tick();
    chk("st_data_held", {32'd0, od}, 64'd1);
    chk("st_valid_held", {63'd0, ov}, 64'd1);
    chk("st_not_accepted", {63'd0, bsy}, 64'd0);
    ordy = 1'b1;
    #1;
    chk("st_in_ready_high", {63'd0, irdy}, 64'd1);
    tick();
    iv = 1'b0;
    chk("st_accepted", {63'd0, bsy}, 64'd1);
    chk("st_drained", {63'd0, ov}, 64'd0);
    beat(23'd4, 1'b1);
    chk("st_data_sum", {32'd0, od}, 64'd54);
    chk("st_count", {56'd0, oc}, 64'd2);
    tick();

    // Back-to-back single-beat groups 5, 7, 9
    iv = 1'b1; il = 1'b1; id = 23'd5;
    tick();
    chk("bb_v5", {63'd0, ov}, 64'd1);
    chk("bb_d5", {32'd0, od}, 64'd5);
    id = 23'd7;
    tick();
    chk("bb_v7", {63'd0, ov}, 64'd1);
    chk("bb_d7", {32'd0, od}, 64'd7);
    id = 23'd9;
    tick();
    chk("bb_v9", {63'd0, ov}, 64'd1);
    chk("bb_d9", {32'd0, od}, 64'd9);
    iv = 1'b0; il = 1'b0;
    tick();
    chk("bb_drained", {63'd0, ov}, 64'd0);

    // 24-bit accumulator overflow: 3 x 0x7FFFFF
`ifdef PSUM_ACC_SAT_EN
    exp24 = 24'hFFFFFF;
`else
    exp24 = 24'h7FFFFD;
`endif
    iv24 = 1'b1; id24 = 23'h7FFFFF; il24 = 1'b0;
    tick();
    tick();
    il24 = 1'b1;
    tick();
    iv24 = 1'b0; il24 = 1'b0;
    chk("ov24_valid", {63'd0, ov24}, 64'd1);
    chk("ov24_ovf", {63'd0, ovf24}, 64'd1);
    chk("ov24_data", {40'd0, od24}, {40'd0, exp24});
    chk("ov24_count", {56'd0, oc24}, 64'd3);
    iv24 = 1'b1; id24 = 23'd1; il24 = 1'b1;
    tick();
    iv24 = 1'b0; il24 = 1'b0;
    chk("ov24_clear_ovf", {63'd0, ovf24}, 64'd0);
    chk("ov24_clear_data", {40'd0, od24}, 64'd1);
    tick();

    // Reset mid-group discards the partial sum
    beat(23'd3, 1'b0);
    beat(23'd4, 1'b0);
    chk("ab_busy", {63'd0, bsy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("ab_rst_busy", {63'd0, bsy}, 64'd0);
    chk("ab_rst_valid", {63'd0, ov}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("ab_no_output", {63'd0, ov}, 64'd0);
    beat(23'd10, 1'b1);
    chk("ab_valid", {63'd0, ov}, 64'd1);
    chk("ab_data", {32'd0, od}, 64'd10);
    chk("ab_count", {56'd0, oc}, 64'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sits directly downstream of the 8-input adder tree (160-bit packed input, 23-bit unsigned sum).
- Accumulates successive tree results over a K-dimension tile sequence into one wider dot-product result per output element.
- Presents each completed result on a valid/ready output register to the writeback/drain logic.
- Decouples the free-running combinational tree from stalls in the drain path.

Parameters:
- IN_W, 23, width of the tree result input (unsigned).
- ACC_W, 32, accumulator and output width; must be >= IN_W.
- CNT_W, 8, width of the per-group beat counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  tree result valid this cycle.
- in_ready  output  1  block can accept a beat.
- in_data  input  IN_W  tree result, unsigned.
- in_last  input  1  beat is the final tile of the current group.
- out_valid  output  1  completed group result held.
- out_ready  input  1  consumer accepts the result.
- out_data  output  ACC_W  accumulated group sum.
- out_count  output  CNT_W  number of beats in the group.
- out_ovf  output  1  accumulator overflowed during the group (sticky per group).
- busy  output  1  partial group in progress (state ACCUM).

Behaviour:
- Reset (async, immediate): state=IDLE, acc=0, cnt=0, ovf=0, out_valid=0, out_data=0, out_count=0, out_ovf=0.
- Reset mid-group discards the partial sum; no output is produced for it.
- Accept condition: acc_fire = in_valid & in_ready. Output handoff: out_fire = out_valid & out_ready.
- in_ready = !out_valid | out_ready. This is combinational from out_ready, so a full output register can be replaced in the same cycle it drains.
- Sum: sum = acc + zero-extend(in_data), computed ACC_W+1 wide. Bit ACC_W is the carry.
- Stored value: the low ACC_W bits of sum, or the saturated value when ACC_SAT_EN is defined.
- States:
  - IDLE: acc=0, no partial group.
  - ACCUM: acc holds a partial sum.
- IDLE, acc_fire & !in_last -> ACCUM: acc=sum, cnt=1, ovf=carry.
- IDLE, acc_fire & in_last: single-beat group. Output register loads sum, count 1, carry; state stays IDLE.
- ACCUM, acc_fire & !in_last: acc=sum, cnt=cnt+1 (wraps at 2^CNT_W), ovf|=carry.
- ACCUM, acc_fire & in_last -> IDLE:
  - Output register loads sum, cnt+1, ovf|carry, and sets out_valid=1.
  - acc, cnt and ovf clear to 0.
- Output register:
  - Loads only on an in_last accept.
  - Holds stable while out_valid & !out_ready.
  - out_valid clears on out_fire unless a new in_last accept occurs in the same cycle; in that case out_valid stays 1 with the new data.
- Latency: a result is visible on out_* the cycle after its in_last beat is accepted.
- Throughput: one beat per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, in_ready=0 and acc is frozen. This applies even to non-last beats; the rule is simple and the cost is accepted.
- in_valid=0: no state change. in_data and in_last are don't-care.
- busy = (state==ACCUM).

Optional Feature:
- Macro: PSUM_ACC_SAT_EN.
- Defined: on carry, the stored value is all-ones (2^ACC_W-1) and further beats keep it saturated. ovf still sets.
- Undefined: modular wrap (low ACC_W bits kept); ovf flags the wrap.
- Port list is identical in both builds.

Decomposition:
- Shared package psum_pkg holds:
  - state enum (IDLE, ACCUM);
  - default widths (PSUM_IN_W=23, PSUM_ACC_W=32, PSUM_CNT_W=8);
  - the saturation constant.
- Natural sub-module: psum_out_reg. It is the single-entry valid/ready output register with same-cycle replace, and is reusable by other drain stages.
- Accumulation and FSM stay in the top.

Test Plan:
- Beats 100, 200, 300 (last on third), out_ready=1 -> next cycle out_valid=1, out_data=600, out_count=3, out_ovf=0; busy=1 during beats 1-2.
- Single beat in_data=0x7FFFFF with in_last -> out_data=0x7FFFFF, out_count=1, state remains IDLE.
- Group completes with out_ready=0, then a new beat is offered -> in_ready=0, out_data held, acc unchanged. Raise out_ready -> the new beat is accepted that cycle.
- Back-to-back single-beat groups 5, 7, 9 with out_ready=1 -> out_data 5, 7, 9 on consecutive cycles; out_valid held high throughout.
- ACC_W=24, beats 0x7FFFFF ×3 (last) -> out_ovf=1. Wrap build: out_data=0x7FFFFD. PSUM_ACC_SAT_EN build: out_data=0xFFFFFF.
- Assert rst after 2 beats of a group, release, send 10 (last) -> out_data=10, out_count=1; no output is produced for the aborted group.
